// File: rtl/frame_update_sequencer.sv
// rtl/frame_update_sequencer.sv - per-frame erase/solve/redraw scheduler for game entities
// Owns the shared drawer and each entity's isActive/startSolve, with a per-step watchdog.
module frame_update_sequencer #(
   parameter int N_ENT   = 3,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             frame_tick,
   input  logic [N_ENT-1:0] solve_done,
   input  logic             draw_done,
   output logic [N_ENT-1:0] is_active,
   output logic             start_solve,
   output logic             draw_req,
   output logic             draw_erase,
   output logic [IDX_W-1:0] draw_sel,
   output logic             busy,
   output logic [N_ENT-1:0] fault,
   output logic [7:0]       overrun_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_SOLVE,
      S_DRAW,
      S_GAP
   } state_t;

   localparam logic [TO_W-1:0]  WD_LAST  = TO_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENT - 1);

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [TO_W-1:0]  r_wdog;
   logic [N_ENT-1:0] r_is_active;
   logic             r_start_solve;
   logic             r_draw_req;
   logic             r_draw_erase;
   logic [IDX_W-1:0] r_draw_sel;
   logic             r_busy;
   logic [N_ENT-1:0] r_fault;
   logic [7:0]       r_overrun_cnt;

   logic [IDX_W-1:0] w_idx_next;
   logic [N_ENT-1:0] w_cur_onehot;
   logic [N_ENT-1:0] w_next_onehot;
   logic             w_wd_fire;
   logic             w_solved;
   logic             w_step_done;
   logic             w_tick_dropped;

   assign w_idx_next     = r_idx + IDX_W'(1);
   assign w_cur_onehot   = N_ENT'(1) << r_idx;
   assign w_next_onehot  = N_ENT'(1) << w_idx_next;
   assign w_wd_fire      = (r_wdog == WD_LAST);
   // A stale isSolved from the entry cycle must not end the solve step.
   assign w_solved       = solve_done[r_idx] && (r_wdog != '0);
   assign w_step_done    = (r_state == S_SOLVE) ? w_solved : draw_done;
   assign w_tick_dropped = frame_tick && (r_state != S_IDLE);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_wdog        <= '0;
         r_is_active   <= '0;
         r_start_solve <= 1'b0;
         r_draw_req    <= 1'b0;
         r_draw_erase  <= 1'b0;
         r_draw_sel    <= '0;
         r_busy        <= 1'b0;
         r_fault       <= '0;
         r_overrun_cnt <= '0;
      end else begin
         if (w_tick_dropped && (r_overrun_cnt != 8'hFF))
            r_overrun_cnt <= r_overrun_cnt + 8'd1;

         case (r_state)
            S_IDLE: begin
               r_wdog <= '0;
               if (frame_tick) begin
                  r_state      <= S_ERASE;
                  r_idx        <= '0;
                  r_busy       <= 1'b1;
                  r_draw_req   <= 1'b1;
                  r_draw_erase <= 1'b1;
                  r_draw_sel   <= '0;
                  r_is_active  <= N_ENT'(1);
               end
            end

            S_ERASE, S_SOLVE, S_DRAW: begin
               r_wdog <= '0;
               // Completion takes priority over a watchdog expiring in the same cycle.
               if (w_step_done) begin
                  if (r_state == S_ERASE) begin
                     r_state       <= S_SOLVE;
                     r_draw_req    <= 1'b0;
                     r_draw_erase  <= 1'b0;
                     r_start_solve <= 1'b1;
                  end else if (r_state == S_SOLVE) begin
                     r_state       <= S_DRAW;
                     r_start_solve <= 1'b0;
                     r_draw_req    <= 1'b1;
                     r_draw_erase  <= 1'b0;
                     r_draw_sel    <= r_idx;
                  end else begin
                     r_state       <= S_GAP;
                     r_draw_req    <= 1'b0;
                     r_is_active   <= '0;
                  end
               end else if (w_wd_fire) begin
                  r_fault       <= r_fault | w_cur_onehot;
                  r_state       <= S_GAP;
                  r_draw_req    <= 1'b0;
                  r_draw_erase  <= 1'b0;
                  r_start_solve <= 1'b0;
                  r_is_active   <= '0;
               end else begin
                  r_wdog <= r_wdog + TO_W'(1);
               end
            end

            S_GAP: begin
               r_wdog <= '0;
               if (r_idx == IDX_LAST) begin
                  r_state    <= S_IDLE;
                  r_idx      <= '0;
                  r_busy     <= 1'b0;
                  r_draw_sel <= '0;
               end else begin
                  r_state      <= S_ERASE;
                  r_idx        <= w_idx_next;
                  r_draw_req   <= 1'b1;
                  r_draw_erase <= 1'b1;
                  r_draw_sel   <= w_idx_next;
                  r_is_active  <= w_next_onehot;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_wdog  <= '0;
            end
         endcase
      end
   end

   assign is_active   = r_is_active;
   assign start_solve = r_start_solve;
   assign draw_req    = r_draw_req;
   assign draw_erase  = r_draw_erase;
   assign draw_sel    = r_draw_sel;
   assign busy        = r_busy;
   assign fault       = r_fault;
   assign overrun_cnt = r_overrun_cnt;

endmodule
